// File: rtl/pc_sequencer.sv
// Program counter and sequencer feeding the program ROM address: increment,
// jumps, call/return through a small return stack, and soft restart.
module pc_sequencer #(
  parameter int                AWIDTH  = 8,
  parameter int                DEPTH   = 4,
  parameter logic [AWIDTH-1:0] RST_VEC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              srst,
  input  logic              jmp,
  input  logic              jmpc,
  input  logic              cond,
  input  logic              call,
  input  logic              ret,
  input  logic [AWIDTH-1:0] target,
  output logic [AWIDTH-1:0] pc,
  output logic              stack_empty,
  output logic              stack_full,
  output logic              err
);

  localparam int SPW   = $clog2(DEPTH + 1);
  localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SLOTS = 1 << IW;
  localparam logic [SPW-1:0] SP_FULL = SPW'(DEPTH);
  localparam logic [SPW-1:0] SP_ZERO = {SPW{1'b0}};

  typedef enum logic [2:0] {
    CMD_HOLD    = 3'd0,
    CMD_RESTART = 3'd1,
    CMD_POP     = 3'd2,
    CMD_PUSH    = 3'd3,
    CMD_JUMP    = 3'd4,
    CMD_INC     = 3'd5
  } cmd_e;

  cmd_e              cmd_s;
  logic [AWIDTH-1:0] pc_r;
  logic [AWIDTH-1:0] pc_nxt_s;
  logic [AWIDTH-1:0] pc_inc_s;
  logic [AWIDTH-1:0] top_s;
  logic [SPW-1:0]    sp_r;
  logic [SPW-1:0]    sp_nxt_s;
  logic [SPW-1:0]    sp_dec_s;
  logic              err_r;
  logic              err_nxt_s;
  logic              empty_r;
  logic              full_r;
  logic              push_s;
  logic              stk_empty_s;
  logic              stk_full_s;
  logic [AWIDTH-1:0] stack_r [SLOTS];

  // Increment wraps naturally at 2^AWIDTH, so a call at all-ones pushes zero.
  assign pc_inc_s    = pc_r + AWIDTH'(1);
  assign sp_dec_s    = sp_r - SPW'(1);
  assign stk_empty_s = (sp_r == SP_ZERO);
  assign stk_full_s  = (sp_r == SP_FULL);
  assign top_s       = stack_r[sp_dec_s[IW-1:0]];

  // Priority decode of the control strobes into a single command.
  always_comb begin
    cmd_s = CMD_HOLD;
    if (srst) begin
      cmd_s = CMD_RESTART;
    end else if (!en) begin
      cmd_s = CMD_HOLD;
    end else if (ret) begin
      cmd_s = CMD_POP;
    end else if (call) begin
      cmd_s = CMD_PUSH;
    end else if (jmp || (jmpc && cond)) begin
      cmd_s = CMD_JUMP;
    end else begin
      cmd_s = CMD_INC;
    end
  end

  // Next PC, stack pointer and fault flag for the decoded command.
  always_comb begin
    pc_nxt_s  = pc_r;
    sp_nxt_s  = sp_r;
    err_nxt_s = err_r;
    push_s    = 1'b0;
    case (cmd_s)
      CMD_RESTART: begin
        pc_nxt_s  = RST_VEC;
        sp_nxt_s  = SP_ZERO;
        err_nxt_s = 1'b0;
      end
      CMD_HOLD: begin
        pc_nxt_s = pc_r;
      end
      CMD_POP: begin
        if (!stk_empty_s) begin
          pc_nxt_s = top_s;
          sp_nxt_s = sp_dec_s;
        end else begin
          // Underflow: flag it and fall through to the next instruction.
          err_nxt_s = 1'b1;
          pc_nxt_s  = pc_inc_s;
        end
      end
      CMD_PUSH: begin
        if (!stk_full_s) begin
          push_s   = 1'b1;
          sp_nxt_s = sp_r + SPW'(1);
          pc_nxt_s = target;
        end else begin
          // Overflow: the call is dropped rather than corrupting the stack.
          err_nxt_s = 1'b1;
          pc_nxt_s  = pc_inc_s;
        end
      end
      CMD_JUMP: begin
        pc_nxt_s = target;
      end
      CMD_INC: begin
        pc_nxt_s = pc_inc_s;
      end
      default: begin
        pc_nxt_s = pc_r;
      end
    endcase
  end

  // Architectural state and registered status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r    <= RST_VEC;
      sp_r    <= SP_ZERO;
      err_r   <= 1'b0;
      empty_r <= 1'b1;
      full_r  <= 1'b0;
    end else begin
      pc_r    <= pc_nxt_s;
      sp_r    <= sp_nxt_s;
      err_r   <= err_nxt_s;
      empty_r <= (sp_nxt_s == SP_ZERO);
      full_r  <= (sp_nxt_s == SP_FULL);
    end
  end

  // Return stack storage; contents are not reset, only the pointer is.
  always_ff @(posedge clk) begin
    if (push_s) begin
      stack_r[sp_r[IW-1:0]] <= pc_inc_s;
    end
  end

  assign pc          = pc_r;
  assign stack_empty = empty_r;
  assign stack_full  = full_r;
  assign err         = err_r;

endmodule
